// File: rtl/movavg_stream.sv
// movavg_stream -- streaming moving-average filter over the last N = 2**LOG2N
// accepted samples. The running sum is maintained incrementally (add newest,
// subtract the sample being overwritten) and presented both at full precision
// and as a mean obtained by a right shift, optionally rounded to nearest.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   clear       synchronous window flush (same effect as reset)
//   din_valid   din carries a new sample this cycle
//   din         unsigned input sample, WL bits
//   dout_valid  one-cycle pulse: dsum/davg were updated by the previous edge
//   dsum        sum of the last N accepted samples, WL+LOG2N bits
//   davg        window mean, WL bits
//   full        N samples accepted since the last reset/clear
module movavg_stream #(
  parameter int WL    = 64,
  parameter int LOG2N = 2,
  parameter int ROUND = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  din_valid,
  input  logic [WL-1:0]         din,
  output logic                  dout_valid,
  output logic [WL+LOG2N-1:0]   dsum,
  output logic [WL-1:0]         davg,
  output logic                  full
);

  localparam int N  = 1 << LOG2N;
  localparam int SW = WL + LOG2N;

  typedef enum logic {FILLING, STEADY} state_t;

  state_t             state_reg, state_next;
  logic [LOG2N:0]     cnt_reg, cnt_next;
  logic [LOG2N-1:0]   wp_reg;
  logic [SW-1:0]      acc_reg, acc_next;
  logic [WL-1:0]      avg_next;
  logic [WL-1:0]      win_mem [N];
  logic               flush;

  assign flush = reset | clear;

  // The oldest sample is read combinationally from the slot about to be
  // overwritten; acc >= that sample always, so the subtraction cannot wrap.
  assign acc_next = acc_reg + SW'(din) - SW'(win_mem[wp_reg]);

  generate
    if (ROUND != 0) begin : g_round
      // One extra bit so adding N/2 to the maximum sum cannot wrap.
      logic [SW:0] rnd_sum;
      assign rnd_sum  = {1'b0, acc_next} + (SW+1)'(N / 2);
      assign avg_next = WL'(rnd_sum >> LOG2N);
    end else begin : g_trunc
      assign avg_next = WL'(acc_next >> LOG2N);
    end
  endgenerate

  // Window storage: each entry is its own register so a flush can zero the
  // whole window in one cycle, giving zero-padded partial sums during warm-up.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_win
      always_ff @(posedge clk) begin
        if (flush) begin
          win_mem[gi] <= '0;
        end else if (din_valid && (wp_reg == LOG2N'(gi))) begin
          win_mem[gi] <= din;
        end
      end
    end
  endgenerate

  // Fill tracking: saturating counter plus FILLING/STEADY state.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (din_valid) begin
      if (cnt_reg != (LOG2N+1)'(N)) begin
        cnt_next = cnt_reg + 1'b1;
      end
      if (cnt_reg == (LOG2N+1)'(N - 1)) begin
        state_next = STEADY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state_reg  <= FILLING;
      cnt_reg    <= '0;
      wp_reg     <= '0;
      acc_reg    <= '0;
      dsum       <= '0;
      davg       <= '0;
      dout_valid <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (din_valid) begin
        acc_reg    <= acc_next;
        wp_reg     <= wp_reg + 1'b1;  // natural wrap N-1 -> 0
        dsum       <= acc_next;
        davg       <= avg_next;
        dout_valid <= 1'b1;
      end else begin
        dout_valid <= 1'b0;
      end
    end
  end

  assign full = (state_reg == STEADY);

endmodule

// File: tb/tb_movavg_stream.sv
module tb_movavg_stream;

  logic        clk = 1'b0;
  logic        reset, clear, din_valid;
  logic [15:0] din16;
  logic [7:0]  din8;

  // Instance A: WL=8, N=4, truncate. Instance B: same with rounding.
  // Instance C: WL=16, N=8, rounding.
  logic        va, vb, vc, fa, fb, fc;
  logic [9:0]  sa, sb;
  logic [18:0] sc;
  logic [7:0]  aa, ab;
  logic [15:0] ac;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: list of samples accepted since the last flush.
  int unsigned hist8[$];
  int unsigned hist16[$];
  logic        exp_valid;
  longint      exp_sa, exp_sc;

  assign din8 = din16[7:0];

  always #5 clk = ~clk;

  movavg_stream #(.WL(8), .LOG2N(2), .ROUND(0)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .din_valid(din_valid), .din(din8),
    .dout_valid(va), .dsum(sa), .davg(aa), .full(fa));

  movavg_stream #(.WL(8), .LOG2N(2), .ROUND(1)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .din_valid(din_valid), .din(din8),
    .dout_valid(vb), .dsum(sb), .davg(ab), .full(fb));

  movavg_stream #(.WL(16), .LOG2N(3), .ROUND(1)) dut_c (
    .clk(clk), .reset(reset), .clear(clear), .din_valid(din_valid), .din(din16),
    .dout_valid(vc), .dsum(sc), .davg(ac), .full(fc));

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Sum of the newest n entries; missing entries count as zero.
  function automatic longint win_sum(input int unsigned q[$], input int n);
    longint s = 0;
    for (int i = 0; i < n && i < q.size(); i++) s += q[q.size() - 1 - i];
    return s;
  endfunction

  // One clock: drive, clock, update model, compare everything.
  task automatic step(input logic v, input int unsigned d, input logic clr, input logic rst);
    @(negedge clk);
    din_valid = v; din16 = 16'(d); clear = clr; reset = rst;
    @(posedge clk);
    #1;
    if (rst || clr) begin
      hist8.delete(); hist16.delete();
      exp_valid = 1'b0; exp_sa = 0; exp_sc = 0;
    end else if (v) begin
      hist8.push_back(d & 32'hFF);
      hist16.push_back(d & 32'hFFFF);
      if (hist8.size() > 16) void'(hist8.pop_front());
      if (hist16.size() > 16) void'(hist16.pop_front());
      exp_valid = 1'b1;
      exp_sa = win_sum(hist8, 4);
      exp_sc = win_sum(hist16, 8);
    end else begin
      exp_valid = 1'b0;
    end
    check("a_valid", va, exp_valid);
    check("a_sum",   sa, exp_sa);
    check("a_avg",   aa, exp_sa / 4);
    check("a_full",  fa, (hist8.size() >= 4));
    check("b_valid", vb, exp_valid);
    check("b_sum",   sb, exp_sa);
    check("b_avg",   ab, (exp_sa + 2) / 4);
    check("b_full",  fb, (hist8.size() >= 4));
    check("c_valid", vc, exp_valid);
    check("c_sum",   sc, exp_sc);
    check("c_avg",   ac, (exp_sc + 4) / 8);
    check("c_full",  fc, (hist16.size() >= 8));
    $display("cycle v=%0b din=%0d clr=%0b rst=%0b -> a:sum=%0d avg=%0d full=%0b b:avg=%0d c:sum=%0d avg=%0d",
             v, d, clr, rst, sa, aa, fa, ab, sc, ac);
  endtask

  initial begin
    int unsigned s1 [5] = '{4, 8, 12, 16, 20};
    int unsigned e1 [5] = '{4, 12, 24, 40, 56};
    int unsigned s5 [5] = '{10, 20, 30, 40, 50};
    reset = 1'b1; clear = 1'b0; din_valid = 1'b0; din16 = '0;
    exp_valid = 1'b0; exp_sa = 0; exp_sc = 0;

    // Reset state
    step(0, 0, 0, 1);
    check("rst_sum", sa, 0);
    check("rst_full", fa, 0);

    // 1: ramp, full rises with the sum-40 beat
    for (int i = 0; i < 5; i++) begin
      step(1, s1[i], 0, 0);
      check("t1_sum", sa, e1[i]);
      check("t1_full", fa, (i >= 3));
    end
    check("t1_avg", aa, 14);

    // 2: gap holds sum/avg with dout_valid low
    step(0, 0, 0, 1);
    step(1, 4, 0, 0);
    step(1, 8, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 77, 0, 0);
      check("t2_hold_sum", sa, 12);
      check("t2_hold_avg", aa, 3);
      check("t2_hold_valid", va, 0);
    end
    step(1, 12, 0, 0);
    check("t2_sum", sa, 24);
    check("t2_avg", aa, 6);

    // 3: rounding of 1.5
    step(0, 0, 0, 1);
    step(1, 1, 0, 0); step(1, 2, 0, 0); step(1, 3, 0, 0);
    check("t3_sum", sa, 6);
    check("t3_trunc", aa, 1);
    check("t3_round", ab, 2);

    // 4: maximum samples, pointer wrap
    step(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 255, 0, 0);
    check("t4_sum", sa, 1020);
    check("t4_trunc", aa, 255);
    check("t4_round", ab, 255);

    // 5: clear with din_valid drops the sample
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, s5[i], 0, 0);
    check("t5_pre_sum", sa, 140);
    step(1, 99, 1, 0);
    check("t5_clr_full", fa, 0);
    check("t5_clr_valid", va, 0);
    step(1, 8, 0, 0);
    check("t5_sum", sa, 8);
    check("t5_avg", aa, 2);

    // 6: reset from STEADY, then refill
    for (int i = 0; i < 3; i++) step(1, 9, 0, 0);
    check("t6_steady", fa, 1);
    step(1, 50, 0, 1);
    check("t6_rst_sum", sa, 0);
    check("t6_rst_avg", aa, 0);
    for (int i = 1; i <= 4; i++) begin
      step(1, 7, 0, 0);
      check("t6_sum", sa, 7 * i);
    end
    check("t6_full", fa, 1);

    // Randomized traffic with occasional clear/reset
    for (int i = 0; i < 400; i++) begin
      logic v, c, r;
      v = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 39) == 0);
      r = ($urandom_range(0, 59) == 0);
      step(v, $urandom_range(0, 65535), c, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
